// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the MiniMicro ALU shift unit.
package alu_pkg;
   typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_op_t;
   localparam int REQ_WIDTH = 32;
   localparam int REQ_AMT_W = 8;
   localparam int REQ_TAG_W = 4;
   typedef struct packed {
      shift_op_t              op;
      logic [REQ_WIDTH-1:0]   data;
      logic [REQ_AMT_W-1:0]   amt;
      logic                   carry;
      logic [REQ_TAG_W-1:0]   tag;
   } shift_req_t;
   localparam bit SH_LSB_FIRST = 1'b1;
endpackage

// File: rtl/shift_core.sv
// shift_core: combinational LSL/LSR/ASR/ROR with Thumb-style carry out.
module shift_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SAT_W = $clog2(WIDTH) + 2
) (
   input  shift_op_t                  op,
   input  logic [WIDTH-1:0]           data,
   input  logic [SAT_W-1:0]           sat_amt,
   input  logic [$clog2(WIDTH)-1:0]   rot_amt,
   input  logic                       zero,
   input  logic                       carry,
   output logic [WIDTH-1:0]           res,
   output logic                       c
);
   // one extra bit below/above the operand catches the last bit shifted out
   logic [WIDTH:0]   lsl, lsr, asr;
   logic [WIDTH-1:0] ror;
   always_comb begin
      lsl = {1'b0, data} << sat_amt;
      lsr = {data, 1'b0} >> sat_amt;
      asr = $signed({data, 1'b0}) >>> sat_amt;
      ror = (data >> rot_amt) | (data << (WIDTH - rot_amt));
      res = zero ? data :
            op == SH_LSL ? lsl[WIDTH-1:0] :
            op == SH_LSR ? lsr[WIDTH:1] :
            op == SH_ASR ? asr[WIDTH:1] : ror;
      c   = zero ? carry :
            op == SH_LSL ? lsl[WIDTH] :
            op == SH_LSR ? lsr[0] :
            op == SH_ASR ? asr[0] : ror[WIDTH-1];
   end
endmodule

// File: rtl/alu_shift_unit.sv
// alu_shift_unit: pipelined shifter with valid/ready handshake and N/Z/C flags.
module alu_shift_unit
   import alu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int AMT_W       = 8,
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  shift_op_t          in_op,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [AMT_W-1:0]   in_amt,
   input  logic               in_carry,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_n,
   output logic               out_z,
   output logic               out_c,
   output logic [TAG_W-1:0]   out_tag
);
   localparam int LOG   = $clog2(WIDTH);
   localparam int SAT_W = LOG + 2;
   localparam int AW    = AMT_W > SAT_W ? AMT_W : SAT_W;
   logic [AW-1:0]    amt_x;
   logic [SAT_W-1:0] pre_sat, st_sat;
   logic [LOG-1:0]   pre_rot, st_rot;
   logic             pre_zero, st_zero, st_v, st_carry, core_c;
   shift_op_t        st_op;
   logic [WIDTH-1:0] st_data, core_d;
   logic [TAG_W-1:0] st_tag;
   assign in_ready = !out_valid || out_ready;
   // rotation needs n mod WIDTH separately, saturation would lose it
   always_comb begin
      amt_x    = AW'(in_amt);
      pre_sat  = amt_x > AW'(2 * WIDTH) ? SAT_W'(2 * WIDTH) : SAT_W'(amt_x);
      pre_rot  = LOG'(amt_x);
      pre_zero = in_amt == '0;
   end
   if (PIPE_STAGES == 2) begin : g_two
      always_ff @(posedge clk) begin
         if (rst) begin
            st_v     <= 1'b0;
            st_op    <= SH_LSL;
            st_data  <= '0;
            st_sat   <= '0;
            st_rot   <= '0;
            st_zero  <= 1'b0;
            st_carry <= 1'b0;
            st_tag   <= '0;
         end else if (in_ready) begin
            st_v     <= in_valid;
            st_op    <= in_op;
            st_data  <= in_data;
            st_sat   <= pre_sat;
            st_rot   <= pre_rot;
            st_zero  <= pre_zero;
            st_carry <= in_carry;
            st_tag   <= in_tag;
         end
      end
   end else begin : g_one
      assign st_v     = in_valid;
      assign st_op    = in_op;
      assign st_data  = in_data;
      assign st_sat   = pre_sat;
      assign st_rot   = pre_rot;
      assign st_zero  = pre_zero;
      assign st_carry = in_carry;
      assign st_tag   = in_tag;
   end
   shift_core #(.WIDTH(WIDTH), .SAT_W(SAT_W)) u_core (
      .op(st_op), .data(st_data), .sat_amt(st_sat), .rot_amt(st_rot),
      .zero(st_zero), .carry(st_carry), .res(core_d), .c(core_c)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_n     <= 1'b0;
         out_z     <= 1'b0;
         out_c     <= 1'b0;
         out_tag   <= '0;
      end else if (in_ready) begin
         out_valid <= st_v;
         out_data  <= core_d;
         out_n     <= core_d[WIDTH-1];
         out_z     <= core_d == '0;
         out_c     <= core_c;
         out_tag   <= st_tag;
      end
   end
endmodule

// File: tb/tb_alu_shift_unit.sv
// tb_alu_shift_unit: directed vectors with a queue scoreboard and decoupled monitor.
module tb_alu_shift_unit;
   import alu_pkg::*;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic in_valid = 1'b0, in_carry = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid, out_n, out_z, out_c;
   shift_op_t in_op = SH_LSL;
   logic [31:0] in_data = '0, out_data;
   logic [7:0]  in_amt = '0;
   logic [3:0]  in_tag = '0, out_tag;
   alu_shift_unit #(.WIDTH(32), .AMT_W(8), .PIPE_STAGES(2), .TAG_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_data(in_data), .in_amt(in_amt), .in_carry(in_carry), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_n(out_n),
      .out_z(out_z), .out_c(out_c), .out_tag(out_tag)
   );
   logic v1 = 1'b0, rdy1, ov1, on1, oz1, oc1;
   shift_op_t op1 = SH_LSL;
   logic [15:0] d1 = '0, od1;
   logic [7:0]  a1 = '0;
   logic [3:0]  ot1;
   alu_shift_unit #(.WIDTH(16), .AMT_W(8), .PIPE_STAGES(1), .TAG_W(4)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_op(op1),
      .in_data(d1), .in_amt(a1), .in_carry(1'b0), .in_tag(4'h3),
      .out_valid(ov1), .out_ready(1'b1), .out_data(od1), .out_n(on1),
      .out_z(oz1), .out_c(oc1), .out_tag(ot1)
   );
   typedef struct {shift_req_t req; logic [31:0] d; logic c;} vec_t;
   typedef struct {logic [31:0] d; logic c; logic [3:0] tag; int acc; bit lat;} exp_t;
   vec_t vecs[$];
   exp_t sb[$];
   int checks = 0, errors = 0, cyc = 0, mode = 0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic add(input shift_op_t op, input logic [31:0] x, input logic [7:0] n,
                      input logic cin, input logic [31:0] d, input logic c);
      vec_t v;
      v.req.op = op; v.req.data = x; v.req.amt = n; v.req.carry = cin; v.req.tag = '0;
      v.d = d; v.c = c;
      vecs.push_back(v);
   endtask
   task automatic send(input int idx, input logic [3:0] tag, input bit push, input bit lat);
      exp_t e;
      int guard = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_op = vecs[idx].req.op; in_data = vecs[idx].req.data;
      in_amt = vecs[idx].req.amt; in_carry = vecs[idx].req.carry; in_tag = tag;
      #1;
      while (!in_ready) begin
         if (++guard > 1000) begin
            $display("FAIL accept timeout tag=%0d", tag);
            $fatal(1);
         end
         @(negedge clk); #1;
      end
      e.d = vecs[idx].d; e.c = vecs[idx].c; e.tag = tag; e.acc = cyc + 1; e.lat = lat;
      if (push) sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask
   // monitor: out_ready chosen for the coming edge, then the transfer is checked
   always @(negedge clk) begin
      exp_t e;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected result: got tag %0d data %h expected none", out_tag, out_data);
         end else begin
            e = sb.pop_front();
            chk($sformatf("data tag%0d", e.tag), out_data, e.d);
            chk($sformatf("carry tag%0d", e.tag), 32'(out_c), 32'(e.c));
            chk($sformatf("n tag%0d", e.tag), 32'(out_n), 32'(e.d[31]));
            chk($sformatf("z tag%0d", e.tag), 32'(out_z), 32'(e.d == 0));
            chk("tag", 32'(out_tag), 32'(e.tag));
            if (e.lat) chk($sformatf("latency tag%0d", e.tag), cyc + 1, e.acc + 2);
         end
      end
      #1;
      if (!rst) chk("in_ready rule", 32'(in_ready), 32'(!out_valid || out_ready));
   end
   task automatic drain();
      for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
      chk("drain queue size", sb.size(), 0);
   endtask
   initial begin
      add(SH_LSL, 32'h8000_0001, 8'd1,   1'b0, 32'h0000_0002, 1'b1);
      add(SH_LSR, 32'h8000_0000, 8'd32,  1'b0, 32'h0000_0000, 1'b1);
      add(SH_LSR, 32'h8000_0000, 8'd33,  1'b1, 32'h0000_0000, 1'b0);
      add(SH_LSR, 32'h1234_5678, 8'd0,   1'b1, 32'h1234_5678, 1'b1);
      add(SH_ASR, 32'h8000_0000, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1);
      add(SH_ROR, 32'h0000_0001, 8'd1,   1'b0, 32'h8000_0000, 1'b1);
      add(SH_ROR, 32'h1234_5678, 8'd64,  1'b1, 32'h1234_5678, 1'b0);
      add(SH_ASR, 32'h8000_0000, 8'd255, 1'b0, 32'hFFFF_FFFF, 1'b1);
      add(SH_LSL, 32'hFFFF_FFFF, 8'd255, 1'b1, 32'h0000_0000, 1'b0);
      add(SH_LSL, 32'h0000_0001, 8'd32,  1'b0, 32'h0000_0000, 1'b1);
      add(SH_LSR, 32'hF000_0000, 8'd4,   1'b1, 32'h0F00_0000, 1'b0);
      add(SH_ASR, 32'h8000_0018, 8'd4,   1'b0, 32'hF800_0001, 1'b1);
      add(SH_ROR, 32'h1234_5678, 8'd200, 1'b1, 32'h7812_3456, 1'b0);
      add(SH_LSL, 32'h1234_5678, 8'd4,   1'b0, 32'h2345_6780, 1'b1);
      add(SH_ASR, 32'h4000_0000, 8'd40,  1'b1, 32'h0000_0000, 1'b0);
      add(SH_ROR, 32'h8000_0001, 8'd4,   1'b1, 32'h1800_0000, 1'b0);
      add(SH_LSR, 32'h8000_0001, 8'd1,   1'b0, 32'h4000_0000, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #1;
      chk("reset out_valid", 32'(out_valid), 0);
      chk("reset out_data", out_data, 0);
      chk("reset flags nzc", {29'b0, out_n, out_z, out_c}, 0);
      chk("reset out_tag", 32'(out_tag), 0);
      chk("reset in_ready", 32'(in_ready), 1);
      // narrow single-stage variant
      @(negedge clk);
      v1 = 1'b1; op1 = SH_LSL; d1 = 16'h00FF; a1 = 8'd12;
      @(posedge clk); #1; v1 = 1'b0;
      @(negedge clk);
      chk("w16 valid at +1", 32'(ov1), 1);
      chk("w16 data", 32'(od1), 32'h0000_F000);
      chk("w16 carry", 32'(oc1), 1);
      chk("w16 n", 32'(on1), 1);
      chk("w16 tag", 32'(ot1), 3);
      @(negedge clk);
      chk("w16 single result", 32'(ov1), 0);
      // directed back-to-back with constant out_ready and latency checks
      for (int i = 0; i < vecs.size(); i++) send(i, 4'(i), 1'b1, 1'b1);
      drain();
      // random backpressure stream
      mode = 1;
      for (int i = 0; i < 16; i++) send(i, 4'(i), 1'b1, 1'b0);
      drain();
      // long stall: pipe fills, then in_ready drops
      mode = 2;
      fork
         for (int i = 0; i < 5; i++) send(i + 3, 4'(i + 8), 1'b1, 1'b0);
         begin
            repeat (8) @(negedge clk);
            #2;
            chk("stalled in_ready", 32'(in_ready), 0);
            mode = 0;
         end
      join
      drain();
      // reset with two ops in flight
      mode = 2;
      @(negedge clk);
      send(0, 4'hA, 1'b0, 1'b0);
      send(1, 4'hB, 1'b0, 1'b0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("flush out_valid", 32'(out_valid), 0);
      chk("flush out_data", out_data, 0);
      chk("flush out_tag", 32'(out_tag), 0);
      mode = 0;
      repeat (6) begin
         @(negedge clk); #2;
         chk("no stale result", 32'(out_valid), 0);
      end
      send(12, 4'h5, 1'b1, 1'b1);
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
